// File: rtl/reiter_column_engine.sv
// rtl/reiter_column_engine.sv - single-column Reiter snowflake engine with u/v cell storage
//
// Purpose: owns the u/v/frozen state of NUM_CELLS hex cells in one column,
// seeds the column, then runs num_steps iterations of a receptive/split sweep
// followed by a diffusion/freeze sweep. Results are read through a side port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle run request, honoured only when idle
//   num_steps             iterations to run (latched on start)
//   alpha, beta, gamma    diffusion constant, background vapour, receptive vapour addition (latched on start)
//   busy, done            run in progress / one-cycle completion pulse
//   steps_done            completed iterations
//   frozen_count          frozen cells after the last completed sweep
//   rd_addr               host read address
//   rd_u, rd_v, rd_frozen cell contents one cycle after rd_addr, held while busy
module reiter_column_engine #(
    parameter int NUM_CELLS = 11,
    parameter int CENTER    = 5,
    parameter int DATA_W    = 18,
    parameter int FRAC_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int STEP_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [DATA_W-1:0] alpha,
    input  logic [DATA_W-1:0] beta,
    input  logic [DATA_W-1:0] gamma,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_done,
    output logic [ADDR_W-1:0] frozen_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_u,
    output logic [DATA_W-1:0] rd_v,
    output logic              rd_frozen
);

    // cnt must reach NUM_CELLS+1 (last diffusion write)
    localparam int CNT_W = $clog2(NUM_CELLS + 2);
    // working width for sums and products; comfortably above 2*DATA_W
    localparam int PW    = 2 * DATA_W + 6;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [PW-1:0]     wide_t;

    localparam wide_t ONE_P     = wide_t'(1) <<< FRAC_W;
    localparam data_t ONE_D     = data_t'(ONE_P);
    // round(2^FRAC_W / 6): 2^FRAC_W mod 6 is 2 or 4, so adding 3 rounds to nearest
    localparam wide_t ONE_SIXTH = (ONE_P + wide_t'(3)) / wide_t'(6);
    localparam wide_t SAT_MAX   = (wide_t'(1) <<< (DATA_W - 1)) - wide_t'(1);
    localparam wide_t SAT_MIN   = -(wide_t'(1) <<< (DATA_W - 1));

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SPLIT,
        S_DIFFUSE,
        S_DONE
    } state_t;

    function automatic data_t sat(input wide_t x);
        if (x > SAT_MAX)      sat = data_t'(SAT_MAX);
        else if (x < SAT_MIN) sat = data_t'(SAT_MIN);
        else                  sat = data_t'(x);
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [STEP_W-1:0]    ns_q;
    data_t                alpha_q;
    data_t                beta_q;
    data_t                gamma_q;
    logic [NUM_CELLS-1:0] frozen;

    // diffusion window: pre-sweep u of cell i-1 and i, plus v of cell i
    data_t                w_prev;
    data_t                w_cur;
    data_t                v_cur;

    // cell RAMs, one registered read port and one write port each
    data_t                u_mem [NUM_CELLS];
    data_t                v_mem [NUM_CELLS];
    data_t                u_q;
    data_t                v_q;

    logic [CNT_W-1:0]     r_idx;
    logic [CNT_W-1:0]     w_idx;
    logic                 u_we;
    logic                 v_we;
    data_t                u_wdata;
    data_t                v_wdata;
    logic [NUM_CELLS-1:0] receptive;
    logic [NUM_CELLS-1:0] frozen_nxt;
    logic [ADDR_W-1:0]    pop_nxt;

    data_t                nb_dn;
    data_t                u_new;
    wide_t                sum_w;
    wide_t                avg_w;
    wide_t                diff_w;
    wide_t                delta_w;
    logic                 freeze_now;

    always_ff @(posedge clk) begin
        if (u_we) u_mem[w_idx] <= u_wdata;
        if (v_we) v_mem[w_idx] <= v_wdata;
        u_q <= u_mem[r_idx];
        v_q <= v_mem[r_idx];
    end

    always_comb begin
        // shifts drop the out-of-range neighbours, which count as not frozen
        receptive = frozen | (frozen << 1) | (frozen >> 1);
        r_idx     = (cnt < CNT_W'(NUM_CELLS)) ? cnt : '0;

        // Diffusion of cell cnt-2: w_prev = u[i-1], w_cur = u[i], u_q = u[i+1].
        // Past the bottom of the column the neighbour is background vapour.
        nb_dn      = (cnt <= CNT_W'(NUM_CELLS)) ? u_q : beta_q;
        sum_w      = wide_t'(w_prev) + wide_t'(nb_dn) + (wide_t'(beta_q) <<< 2);
        avg_w      = (sum_w * ONE_SIXTH) >>> FRAC_W;
        diff_w     = avg_w - wide_t'(w_cur);
        delta_w    = (wide_t'(alpha_q >>> 1) * diff_w) >>> FRAC_W;
        u_new      = sat(wide_t'(w_cur) + delta_w);
        freeze_now = (wide_t'(u_new) + wide_t'(v_cur)) >= ONE_P;

        u_we       = 1'b0;
        v_we       = 1'b0;
        w_idx      = '0;
        u_wdata    = '0;
        v_wdata    = '0;
        frozen_nxt = frozen;

        case (state)
            S_INIT: begin
                u_we  = 1'b1;
                v_we  = 1'b1;
                w_idx = cnt;
                if (cnt == CNT_W'(CENTER)) begin
                    u_wdata         = '0;
                    v_wdata         = ONE_D;
                    frozen_nxt[cnt] = 1'b1;
                end else begin
                    u_wdata         = beta_q;
                    v_wdata         = '0;
                    frozen_nxt[cnt] = 1'b0;
                end
            end
            S_SPLIT: begin
                // read of cell k issued at cnt=k, its data arrives at cnt=k+1
                if (cnt != '0) begin
                    u_we  = 1'b1;
                    v_we  = 1'b1;
                    w_idx = cnt - CNT_W'(1);
                    if (receptive[w_idx]) begin
                        u_wdata = '0;
                        v_wdata = sat(wide_t'(u_q) + wide_t'(v_q) + wide_t'(gamma_q));
                    end else begin
                        u_wdata = sat(wide_t'(u_q) + wide_t'(v_q));
                        v_wdata = '0;
                    end
                end
            end
            S_DIFFUSE: begin
                // cell i is written two cycles after its read; cell i+1 was
                // already read by then, so only pre-sweep values are used
                if (cnt >= CNT_W'(2)) begin
                    u_we              = 1'b1;
                    w_idx             = cnt - CNT_W'(2);
                    u_wdata           = u_new;
                    frozen_nxt[w_idx] = frozen[w_idx] | freeze_now;
                end
            end
            default: ;
        endcase

        pop_nxt = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            pop_nxt = pop_nxt + ADDR_W'(frozen_nxt[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ns_q         <= '0;
            alpha_q      <= '0;
            beta_q       <= '0;
            gamma_q      <= '0;
            frozen       <= '0;
            w_prev       <= '0;
            w_cur        <= '0;
            v_cur        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            steps_done   <= '0;
            frozen_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ns_q       <= num_steps;
                        alpha_q    <= alpha;
                        beta_q     <= beta;
                        gamma_q    <= gamma;
                        steps_done <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= S_INIT;
                    end
                end
                S_INIT: begin
                    frozen <= frozen_nxt;
                    if (cnt == CNT_W'(NUM_CELLS - 1)) begin
                        cnt          <= '0;
                        frozen_count <= pop_nxt;
                        if (ns_q == '0) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_SPLIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SPLIT: begin
                    if (cnt == CNT_W'(NUM_CELLS)) begin
                        cnt    <= '0;
                        // the cell above the top of the column is background vapour
                        w_prev <= beta_q;
                        w_cur  <= beta_q;
                        state  <= S_DIFFUSE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DIFFUSE: begin
                    frozen <= frozen_nxt;
                    if (cnt != '0) begin
                        w_prev <= w_cur;
                        w_cur  <= u_q;
                        v_cur  <= v_q;
                    end
                    if (cnt == CNT_W'(NUM_CELLS + 1)) begin
                        cnt          <= '0;
                        steps_done   <= steps_done + STEP_W'(1);
                        frozen_count <= pop_nxt;
                        if (steps_done + STEP_W'(1) == ns_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_SPLIT;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // host readout; frozen while a run owns the RAMs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_u      <= '0;
            rd_v      <= '0;
            rd_frozen <= 1'b0;
        end else if (!busy) begin
            if (rd_addr < ADDR_W'(NUM_CELLS)) begin
                rd_u      <= u_mem[rd_addr[CNT_W-1:0]];
                rd_v      <= v_mem[rd_addr[CNT_W-1:0]];
                rd_frozen <= frozen[rd_addr[CNT_W-1:0]];
            end else begin
                rd_u      <= '0;
                rd_v      <= '0;
                rd_frozen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reiter_column_engine.sv
// tb/tb_reiter_column_engine.sv - scoreboard bench for reiter_column_engine
module tb_reiter_column_engine;

    localparam int N  = 11;
    localparam int C  = 5;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   num_steps;
    logic [DW-1:0] alpha;
    logic [DW-1:0] beta;
    logic [DW-1:0] gamma;
    logic          busy;
    logic          done;
    logic [15:0]   steps_done;
    logic [15:0]   frozen_count;
    logic [15:0]   rd_addr;
    logic [DW-1:0] rd_u;
    logic [DW-1:0] rd_v;
    logic          rd_frozen;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;

    typedef struct {
        logic [DW-1:0] u;
        logic [DW-1:0] v;
        logic          f;
    } cell_t;

    typedef struct {
        logic [15:0] steps;
        logic [15:0] fc;
    } run_t;

    cell_t cell_q[$];
    run_t  run_q[$];

    longint mu[N];
    longint mv[N];
    bit     mf[N];
    int     m_fc;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_pulses++;
    end

    reiter_column_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_steps    (num_steps),
        .alpha        (alpha),
        .beta         (beta),
        .gamma        (gamma),
        .busy         (busy),
        .done         (done),
        .steps_done   (steps_done),
        .frozen_count (frozen_count),
        .rd_addr      (rd_addr),
        .rd_u         (rd_u),
        .rd_v         (rd_v),
        .rd_frozen    (rd_frozen)
    );

    function automatic longint msat(input longint x);
        if (x > 131071)  return 131071;
        if (x < -131072) return -131072;
        return x;
    endfunction

    // reference: whole-column array arithmetic, one step at a time
    task automatic model_run(input longint a, input longint b, input longint g, input int steps);
        longint old[N];
        longint up, dn, sum, avg, un;
        bit     rec;
        for (int i = 0; i < N; i++) begin
            mu[i] = (i == C) ? 0 : b;
            mv[i] = (i == C) ? 65536 : 0;
            mf[i] = (i == C);
        end
        for (int s = 0; s < steps; s++) begin
            for (int i = 0; i < N; i++) begin
                rec = mf[i];
                if (i > 0 && mf[i-1]) rec = 1;
                if (i < N - 1 && mf[i+1]) rec = 1;
                if (rec) begin
                    mv[i] = msat(mu[i] + mv[i] + g);
                    mu[i] = 0;
                end else begin
                    mu[i] = msat(mu[i] + mv[i]);
                    mv[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) old[i] = mu[i];
            for (int i = 0; i < N; i++) begin
                up  = (i > 0) ? old[i-1] : b;
                dn  = (i < N - 1) ? old[i+1] : b;
                sum = up + dn + 4 * b;
                avg = (sum * 10923) >>> 16;
                un  = msat(old[i] + (((a >>> 1) * (avg - old[i])) >>> 16));
                mu[i] = un;
                if (un + mv[i] >= 65536) mf[i] = 1;
            end
        end
        m_fc = 0;
        for (int i = 0; i < N; i++) if (mf[i]) m_fc++;
    endtask

    task automatic run_engine(input int steps, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] g, input logic [15:0] e_fc, output logic [15:0] got_fc);
        run_t e;
        run_t r;
        int   cyc;
        @(negedge clk);
        num_steps = 16'(steps);
        alpha = a;
        beta  = b;
        gamma = g;
        start = 1'b1;
        e.steps = 16'(steps);
        e.fc    = e_fc;
        run_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start got=%0b want=1", busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        r = run_q.pop_front();
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout steps=%0d got done=%0b want=1", steps, done);
        end
        total++;
        if (steps_done !== r.steps) begin
            bad++;
            $display("FAIL steps_done got=%0d want=%0d", steps_done, r.steps);
        end
        total++;
        if (frozen_count !== r.fc) begin
            bad++;
            $display("FAIL frozen_count steps=%0d got=%0d want=%0d", steps, frozen_count, r.fc);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_at_done got=%0b want=0", busy);
        end
        got_fc = frozen_count;
    endtask

    task automatic read_expect(input logic [15:0] addr, input logic [DW-1:0] eu,
                               input logic [DW-1:0] ev, input logic ef);
        cell_t e;
        cell_t r;
        @(negedge clk);
        rd_addr = addr;
        e.u = eu;
        e.v = ev;
        e.f = ef;
        cell_q.push_back(e);
        @(negedge clk);
        r = cell_q.pop_front();
        total++;
        if (rd_u !== r.u) begin
            bad++;
            $display("FAIL rd_u addr=%0d got=%h want=%h", addr, rd_u, r.u);
        end
        total++;
        if (rd_v !== r.v) begin
            bad++;
            $display("FAIL rd_v addr=%0d got=%h want=%h", addr, rd_v, r.v);
        end
        total++;
        if (rd_frozen !== r.f) begin
            bad++;
            $display("FAIL rd_frozen addr=%0d got=%0b want=%0b", addr, rd_frozen, r.f);
        end
    endtask

    task automatic check_model_cells();
        for (int i = 0; i < N; i++) begin
            read_expect(16'(i), DW'(mu[i]), DW'(mv[i]), mf[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        num_steps = '0;
        alpha = '0;
        beta  = '0;
        gamma = '0;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0)          begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
        total++; if (steps_done !== 16'd0)   begin bad++; $display("FAIL reset_steps got=%0d want=0", steps_done); end
        total++; if (frozen_count !== 16'd0) begin bad++; $display("FAIL reset_fc got=%0d want=0", frozen_count); end
        total++; if (rd_u !== '0)            begin bad++; $display("FAIL reset_rd_u got=%h want=0", rd_u); end
        total++; if (rd_v !== '0)            begin bad++; $display("FAIL reset_rd_v got=%h want=0", rd_v); end
        total++; if (rd_frozen !== 1'b0)     begin bad++; $display("FAIL reset_rd_frozen got=%0b want=0", rd_frozen); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_steps();
        logic [15:0] fc;
        run_engine(0, 18'h10000, 18'h04000, 18'h0, 16'd1, fc);
        for (int i = 0; i < N; i++) begin
            if (i == C) read_expect(16'(i), 18'h0, 18'h10000, 1'b1);
            else        read_expect(16'(i), 18'h04000, 18'h0, 1'b0);
        end
        read_expect(16'(N), 18'h0, 18'h0, 1'b0);
        read_expect(16'hFFFF, 18'h0, 18'h0, 1'b0);
    endtask

    task automatic test_one_step();
        logic [15:0] fc;
        model_run(64'h10000, 64'h4000, 0, 1);
        run_engine(1, 18'h10000, 18'h04000, 18'h0, 16'd1, fc);
        read_expect(16'd3, 18'h03AAA, 18'h0, 1'b0);
        read_expect(16'd4, 18'h01AAA, 18'h04000, 1'b0);
        read_expect(16'd5, DW'(mu[5]), 18'h10000, 1'b1);
        check_model_cells();
    endtask

    task automatic test_gamma_freeze();
        logic [15:0] fc;
        model_run(64'h10000, 64'h4000, 64'h10000, 1);
        run_engine(1, 18'h10000, 18'h04000, 18'h10000, 16'd3, fc);
        check_model_cells();
        model_run(64'h10000, 64'h4000, 64'h10000, 2);
        run_engine(2, 18'h10000, 18'h04000, 18'h10000, 16'd5, fc);
        check_model_cells();
    endtask

    task automatic test_saturation();
        logic [15:0] fc;
        logic [15:0] prev_fc;
        prev_fc = '0;
        for (int s = 1; s <= 20; s++) begin
            model_run(64'h10000, 64'h4000, 64'h1FFFF, s);
            run_engine(s, 18'h10000, 18'h04000, 18'h1FFFF, 16'(m_fc), fc);
            if (s > 1) begin
                total++;
                if (fc < prev_fc) begin
                    bad++;
                    $display("FAIL fc_monotonic steps=%0d got=%0d want>=%0d", s, fc, prev_fc);
                end
            end
            prev_fc = fc;
        end
        read_expect(16'(C), DW'(mu[C]), 18'h1FFFF, 1'b1);
        check_model_cells();
    endtask

    task automatic test_reset_abort();
        logic [15:0] fc;
        @(negedge clk);
        num_steps = 16'd5;
        alpha = 18'h10000;
        beta  = 18'h04000;
        gamma = 18'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // INIT 11 + two steps of 25 + SPLIT 12 + 5 cycles into DIFFUSE of step 3
        repeat (78) @(negedge clk);
        total++;
        if (busy !== 1'b1 || steps_done !== 16'd2) begin
            bad++;
            $display("FAIL abort_pre got busy=%0b steps=%0d want busy=1 steps=2", busy, steps_done);
        end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL abort_done got=%0b want=0", done); end
        total++; if (steps_done !== 16'd0) begin bad++; $display("FAIL abort_steps got=%0d want=0", steps_done); end
        @(negedge clk);
        reset = 1'b0;
        run_engine(1, 18'h10000, 18'h04000, 18'h0, 16'd1, fc);
        read_expect(16'd3, 18'h03AAA, 18'h0, 1'b0);
        read_expect(16'd4, 18'h01AAA, 18'h04000, 1'b0);
        read_expect(16'd5, 18'h01555, 18'h10000, 1'b1);
    endtask

    task automatic test_ignored_start();
        int   pulses_before;
        int   cyc;
        run_t e;
        run_t r;
        model_run(64'h10000, 64'h4000, 0, 2);
        pulses_before = done_pulses;
        @(negedge clk);
        num_steps = 16'd2;
        alpha = 18'h10000;
        beta  = 18'h04000;
        gamma = 18'h0;
        start = 1'b1;
        e.steps = 16'd2;
        e.fc    = 16'(m_fc);
        run_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        num_steps = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num_steps = 16'd2;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        // pulse start in the done cycle itself
        num_steps = 16'd9;
        start = 1'b1;
        r = run_q.pop_front();
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL ign_timeout got done=%0b want=1", done); end
        total++;
        if (steps_done !== r.steps) begin bad++; $display("FAIL ign_steps got=%0d want=%0d", steps_done, r.steps); end
        total++;
        if (frozen_count !== r.fc) begin bad++; $display("FAIL ign_fc got=%0d want=%0d", frozen_count, r.fc); end
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy !== 1'b0) cyc++;
            @(negedge clk);
        end
        total++;
        if (cyc != 0) begin bad++; $display("FAIL ign_busy_reasserted got=%0d busy cycles want=0", cyc); end
        total++;
        if (done_pulses - pulses_before != 1) begin
            bad++;
            $display("FAIL ign_done_pulses got=%0d want=1", done_pulses - pulses_before);
        end
        check_model_cells();
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_zero_steps();
        test_one_step();
        test_gamma_freeze();
        test_saturation();
        test_reset_abort();
        test_ignored_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
